donut_ray_sequencer: RTL and testbench
======================================

// Module: donut_ray_sequencer
// PURPOSE
//  Per-scanline ray issuer/collector wrapped around donuthit. On line_start it walks
//  PIX_PER_LINE rays: per ray it drives the ray direction, pulses start and waits ITERS march
//  clocks. It then samples hit/light, quantises them to a 6-bit shade and hands the shade to
//  the downstream pixel buffer over a valid/ready handshake.
// PARAMETERS
//  PIX_PER_LINE  160  rays per line; pixel index counts 0..PIX_PER_LINE-1
//  ITERS         8    march clocks between start pulse and result sample
//  PIXW          8    width of pix_idx (must hold PIX_PER_LINE-1)
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     async active-low reset
//  line_start   in   1     1-cycle pulse: begin a new line (aborts any line in progress)
//  rx0          in   16s   ray x-direction for pixel 0 (latched on line_start)
//  drx          in   16s   per-pixel rx increment (latched on line_start)
//  ry_in        in   16s   ray y-direction for this line (latched on line_start)
//  rz_in        in   16s   ray z-direction for this line (latched on line_start)
//  hit_start    out  1     start pulse to donuthit
//  rx,ry,rz     out  16s   ray direction to donuthit, stable from start until sample
//  hit          in   1     donuthit hit flag
//  light        in   16s   donuthit light intensity
//  shade        out  6     quantised pixel shade
//  pix_idx      out  PIXW  pixel index of shade
//  shade_valid  out  1     shade/pix_idx valid
//  shade_ready  in   1     downstream accepts when valid&ready
//  line_done    out  1     1-cycle pulse after last pixel of a line is accepted
//  busy         out  1     high from line_start until line_done
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; counters 0; rx/ry/rz 0.
//  FSM states: IDLE, LAUNCH, MARCH, EMIT.
//   IDLE: line_start -> latch rx0/drx/ry_in/rz_in; rx<=rx0; pix_idx<=0; go to LAUNCH.
//   LAUNCH: hit_start=1 for exactly this cycle; iter counter<=0; go to MARCH.
//   MARCH: counter increments once per clock; after ITERS MARCH cycles, register
//    shade from hit/light and set shade_valid; go to EMIT. Sample edge = start+ITERS+1.
//   EMIT: hold shade/pix_idx/shade_valid stable until shade_ready.
//    On accept: if pix_idx==PIX_PER_LINE-1 -> line_done pulse, busy<=0, IDLE.
//    Otherwise pix_idx+1, rx<=rx+drx (16-bit wrap, no saturation), LAUNCH next cycle.
//  Shade mapping, evaluated at the sample edge:
//   !hit -> 0.
//   hit && light<=0 -> 1 (ambient floor).
//   hit && light>=16384 -> 63.
//   otherwise -> max(light[13:8], 1).
//  Throughput: ITERS+2 clocks per pixel when shade_ready is held high.
//  line_start in any non-IDLE state:
//   abort; shade_valid drops next cycle; no line_done pulse.
//   Relatch inputs and restart at pixel 0 (LAUNCH).
//  line_start in the same cycle as the final accept: restart wins; no line_done pulse.
//  rx/ry/rz change only on line_start latch or on an accept; never during MARCH.
//  busy=1 in every state except IDLE.
//  rst_n low mid-line: immediate return to reset values; no partial outputs.
// STRUCTURE
//  Shared package donut_pkg: SHADE_W=6, SHADE_MISS=0, SHADE_AMBIENT=1, SHADE_MAX=63, and
//   the FSM state encoding.
//  One sub-module, donut_shade_quant: combinational hit/light -> 6-bit shade, reused by the
//   palette stage.
//  donuthit itself is instantiated by the parent. This block only drives and observes it.
// TESTING
//  Bench contains a donuthit behavioural model with configurable hit/light.
//  1) PIX_PER_LINE=4, ITERS=8, ready=1, rx0=0, drx=0x0100:
//     shade_valid every 10 clks with rx=0,0x100,0x200,0x300 and pix_idx 0..3;
//     line_done 1 clk after pix 3 accept.
//  2) Shade map: (hit=0, light=9999)->0; (1,-5)->1; (1,0x00FF)->1; (1,0x1A00)->26;
//     (1,0x4000)->63; (1,0x7FFF)->63.
//  3) Backpressure: ready low for 5 clks in EMIT -> shade/pix_idx stable and no new
//     hit_start; next hit_start exactly 1 clk after accept.
//  4) line_start pulsed during pixel 2 MARCH -> shade_valid low next clk; no line_done;
//     hit_start after 1 clk with pix_idx=0 and new rx0/ry/rz.
//  5) rst_n low during EMIT -> all outputs 0 asynchronously; after release, idle until
//     line_start.
//  6) rx wrap: rx0=0x7F00, drx=0x0200 -> pixel 1 rx=0x8100 (signed wrap, no saturation).

Source files
------------

// File: rtl/donut_pkg.sv
// Shared definitions for the donut ray sequencer and its shade quantiser:
// shade width and fixed shade levels, the light saturation point, the ray
// direction payload handed to donuthit and the sequencer FSM encoding.
package donut_pkg;

    localparam int unsigned SHADE_W = 6;
    localparam int unsigned RAY_W   = 16;

    localparam logic [SHADE_W-1:0] SHADE_MISS    = SHADE_W'(0);
    localparam logic [SHADE_W-1:0] SHADE_AMBIENT = SHADE_W'(1);
    localparam logic [SHADE_W-1:0] SHADE_MAX     = SHADE_W'(63);

    // Light at or above this value saturates to SHADE_MAX.
    localparam logic signed [RAY_W-1:0] LIGHT_SAT = 16'sd16384;

    // Ray direction presented to donuthit.
    typedef struct packed {
        logic signed [RAY_W-1:0] rx;
        logic signed [RAY_W-1:0] ry;
        logic signed [RAY_W-1:0] rz;
    } ray_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_MARCH  = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/donut_shade_quant.sv
// Combinational hit/light -> 6-bit shade quantiser (shared with the palette stage).
// Ports:
//   i_hit      in   1   donuthit hit flag
//   i_light    in   16s donuthit light intensity
//   o_shade_c  out  6   quantised shade (combinational)
module donut_shade_quant
    import donut_pkg::*;
(
    input  logic                    i_hit,
    input  logic signed [RAY_W-1:0] i_light,
    output logic [SHADE_W-1:0]      o_shade_c
);

    logic [SHADE_W-1:0] w_frac;

    // Light is Q-ish with 256 counts per shade step below saturation.
    assign w_frac = i_light[13:8];

    always_comb begin
        o_shade_c = SHADE_MISS;
        if (!i_hit) begin
            o_shade_c = SHADE_MISS;
        end else if (i_light <= 16'sd0) begin
            o_shade_c = SHADE_AMBIENT;
        end else if (i_light >= LIGHT_SAT) begin
            o_shade_c = SHADE_MAX;
        end else if (w_frac == '0) begin
            // Faint but lit surfaces never drop below the ambient floor.
            o_shade_c = SHADE_AMBIENT;
        end else begin
            o_shade_c = w_frac;
        end
    end

endmodule

// File: rtl/donut_ray_sequencer.sv
// Per-scanline ray issuer/collector around donuthit. For each pixel it
// presents a ray, pulses hit_start, waits ITERS march clocks, quantises the
// hit/light result and offers it downstream over valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   line_start                 begin (or restart) a line; latches rx0/drx/ry_in/rz_in
//   rx0, drx, ry_in, rz_in     line ray setup (16-bit signed)
//   hit_start                  one-cycle start pulse to donuthit
//   rx, ry, rz                 ray direction to donuthit
//   hit, light                 donuthit result
//   shade, pix_idx             pixel result and its index
//   shade_valid, shade_ready   downstream handshake
//   line_done                  pulse after the last pixel is accepted
//   busy                       high whenever a line is in progress
module donut_ray_sequencer
    import donut_pkg::*;
#(
    parameter int unsigned PIX_PER_LINE = 160,
    parameter int unsigned ITERS        = 8,
    parameter int unsigned PIXW         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_start,
    input  logic signed [RAY_W-1:0] rx0,
    input  logic signed [RAY_W-1:0] drx,
    input  logic signed [RAY_W-1:0] ry_in,
    input  logic signed [RAY_W-1:0] rz_in,
    output logic                    hit_start,
    output logic signed [RAY_W-1:0] rx,
    output logic signed [RAY_W-1:0] ry,
    output logic signed [RAY_W-1:0] rz,
    input  logic                    hit,
    input  logic signed [RAY_W-1:0] light,
    output logic [SHADE_W-1:0]      shade,
    output logic [PIXW-1:0]         pix_idx,
    output logic                    shade_valid,
    input  logic                    shade_ready,
    output logic                    line_done,
    output logic                    busy
);

    localparam int unsigned     ITW       = $clog2(ITERS) + 1;
    localparam logic [ITW-1:0]  LAST_ITER = ITW'(ITERS - 1);
    localparam logic [PIXW-1:0] LAST_PIX  = PIXW'(PIX_PER_LINE - 1);

    state_t                  r_state,     w_state_nxt;
    ray_t                    r_ray,       w_ray_nxt;
    logic signed [RAY_W-1:0] r_drx,       w_drx_nxt;
    logic [ITW-1:0]          r_iter,      w_iter_nxt;
    logic [PIXW-1:0]         r_pix,       w_pix_nxt;
    logic [SHADE_W-1:0]      r_shade,     w_shade_nxt;
    logic                    r_valid,     w_valid_nxt;
    logic                    r_line_done, w_line_done_nxt;
    logic                    r_hit_start, w_hit_start_nxt;
    logic                    r_busy,      w_busy_nxt;
    logic [SHADE_W-1:0]      w_shade_c;

    donut_shade_quant u_quant (
        .i_hit     (hit),
        .i_light   (light),
        .o_shade_c (w_shade_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ray       <= '0;
            r_drx       <= '0;
            r_iter      <= '0;
            r_pix       <= '0;
            r_shade     <= '0;
            r_valid     <= 1'b0;
            r_line_done <= 1'b0;
            r_hit_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ray       <= w_ray_nxt;
            r_drx       <= w_drx_nxt;
            r_iter      <= w_iter_nxt;
            r_pix       <= w_pix_nxt;
            r_shade     <= w_shade_nxt;
            r_valid     <= w_valid_nxt;
            r_line_done <= w_line_done_nxt;
            r_hit_start <= w_hit_start_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; line_start overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_ray_nxt       = r_ray;
        w_drx_nxt       = r_drx;
        w_iter_nxt      = r_iter;
        w_pix_nxt       = r_pix;
        w_shade_nxt     = r_shade;
        w_valid_nxt     = r_valid;
        w_line_done_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_LAUNCH: begin
                w_iter_nxt  = '0;
                w_state_nxt = ST_MARCH;
            end
            ST_MARCH: begin
                w_iter_nxt = r_iter + 1'b1;
                if (r_iter == LAST_ITER) begin
                    w_shade_nxt = w_shade_c;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (shade_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_pix == LAST_PIX) begin
                        w_line_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_pix_nxt    = r_pix + 1'b1;
                        w_ray_nxt.rx = r_ray.rx + r_drx;
                        w_state_nxt  = ST_LAUNCH;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new line aborts whatever is in flight, including a final accept.
        if (line_start) begin
            w_ray_nxt       = '{rx: rx0, ry: ry_in, rz: rz_in};
            w_drx_nxt       = drx;
            w_pix_nxt       = '0;
            w_iter_nxt      = '0;
            w_valid_nxt     = 1'b0;
            w_line_done_nxt = 1'b0;
            w_state_nxt     = ST_LAUNCH;
        end
    end

    // hit_start is high exactly while the FSM sits in LAUNCH.
    assign w_hit_start_nxt = (w_state_nxt == ST_LAUNCH);
    assign w_busy_nxt      = (w_state_nxt != ST_IDLE);

    assign hit_start   = r_hit_start;
    assign rx          = r_ray.rx;
    assign ry          = r_ray.ry;
    assign rz          = r_ray.rz;
    assign shade       = r_shade;
    assign pix_idx     = r_pix;
    assign shade_valid = r_valid;
    assign line_done   = r_line_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_donut_ray_sequencer.sv
// Self-checking bench for donut_ray_sequencer with a donuthit behavioural model
// and a shade/ray reference computed from plain arithmetic.
module tb_donut_ray_sequencer;

    localparam int unsigned NPIX  = 4;
    localparam int unsigned ITERS = 8;
    localparam int unsigned PIXW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_start = 1'b0;
    logic signed [15:0] rx0 = '0, drx = '0, ry_in = '0, rz_in = '0;
    logic hit_start;
    logic signed [15:0] rx, ry, rz;
    logic hit = 1'b0;
    logic signed [15:0] light = '0;
    logic [5:0] shade;
    logic [PIXW-1:0] pix_idx;
    logic shade_valid;
    logic shade_ready = 1'b1;
    logic line_done;
    logic busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    donut_ray_sequencer #(.PIX_PER_LINE(NPIX), .ITERS(ITERS), .PIXW(PIXW)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .rx0(rx0), .drx(drx), .ry_in(ry_in), .rz_in(rz_in),
        .hit_start(hit_start), .rx(rx), .ry(ry), .rz(rz),
        .hit(hit), .light(light), .shade(shade), .pix_idx(pix_idx),
        .shade_valid(shade_valid), .shade_ready(shade_ready),
        .line_done(line_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // donuthit model: each start pulse consumes the next configured result.
    bit              cfg_hit [256];
    logic [15:0]     cfg_light [256];
    int              mk = 0;
    always @(negedge clk) begin
        if (hit_start) begin
            hit   <= cfg_hit[mk % 256];
            light <= cfg_light[mk % 256];
            mk    <= mk + 1;
        end
    end

    // Event recorder: accepted pixels, start pulses, line_done pulses.
    typedef struct {
        int          stamp;
        int          pix;
        logic [5:0]  sh;
        logic [15:0] x, y, z;
    } acc_t;
    acc_t acc_q[$];
    int   hs_q[$];
    int   ld_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (shade_valid && shade_ready)
                acc_q.push_back('{cyc, int'(pix_idx), shade, rx, ry, rz});
            if (hit_start) hs_q.push_back(cyc);
            if (line_done) ld_q.push_back(cyc);
        end
    end

    function automatic logic [5:0] ref_shade(input bit h, input logic [15:0] l16);
        int l;
        l = int'($signed(l16));
        if (!h) return 6'd0;
        if (l <= 0) return 6'd1;
        if (l >= 16384) return 6'd63;
        if (l < 256) return 6'd1;
        return 6'(l / 256);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int k, input bit h, input logic [15:0] l, output logic [5:0] e);
        cfg_hit[(mk + k) % 256]   = h;
        cfg_light[(mk + k) % 256] = l;
        e = ref_shade(h, l);
    endtask

    task automatic fill_rand(output logic [5:0] e [NPIX]);
        for (int k = 0; k < int'(NPIX); k++)
            set_cfg(k, ($urandom_range(0, 3) != 0), 16'($urandom), e[k]);
    endtask

    task automatic pulse_line(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d, output int t0);
        rx0 = a; drx = b; ry_in = c; rz_in = d;
        line_start = 1'b1;
        t0 = cyc;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_ld(input int n, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            if (ld_q.size() >= n) begin ok = 1'b1; break; end
            step();
        end
        if (ld_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            if (shade_valid) begin ok = 1'b1; break; end
            step();
        end
        if (shade_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [65:0] o;
        step(); step();
        o = {hit_start, rx, ry, rz, shade, pix_idx, shade_valid, line_done, busy};
        total++; if (o !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
        rst_n = 1'b1;
        repeat (3) step();
        o = {hit_start, rx, ry, rz, shade, pix_idx, shade_valid, line_done, busy};
        total++; if (o !== '0) begin bad++; $display("FAIL idle_after_reset got=%h want=0", o); end
    endtask

    task automatic test_basic_line();
        logic [5:0] e [NPIX];
        logic [15:0] y, z;
        int t0, a0, h0, l0;
        bit ok;
        shade_ready = 1'b1;
        fill_rand(e);
        y = 16'($urandom); z = 16'($urandom);
        a0 = acc_q.size(); h0 = hs_q.size(); l0 = ld_q.size();
        pulse_line(16'h0000, 16'h0100, y, z, t0);
        wait_ld(l0 + 1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
        total++; if (acc_q.size() - a0 != int'(NPIX)) begin bad++; $display("FAIL basic_count got=%0d want=%0d", acc_q.size() - a0, NPIX); end
        if (ok && acc_q.size() - a0 == int'(NPIX)) begin
            for (int k = 0; k < int'(NPIX); k++) begin
                total++; if (acc_q[a0+k].stamp != t0 + 10 + 10*k) begin bad++; $display("FAIL basic_valid_time pix=%0d got=%0d want=%0d", k, acc_q[a0+k].stamp, t0 + 10 + 10*k); end
                total++; if (hs_q[h0+k] != t0 + 1 + 10*k) begin bad++; $display("FAIL basic_start_time pix=%0d got=%0d want=%0d", k, hs_q[h0+k], t0 + 1 + 10*k); end
                total++; if (acc_q[a0+k].pix != k) begin bad++; $display("FAIL basic_pix got=%0d want=%0d", acc_q[a0+k].pix, k); end
                total++; if (acc_q[a0+k].x !== 16'(k * 256)) begin bad++; $display("FAIL basic_rx pix=%0d got=%h want=%h", k, acc_q[a0+k].x, 16'(k * 256)); end
                total++; if ({acc_q[a0+k].y, acc_q[a0+k].z} !== {y, z}) begin bad++; $display("FAIL basic_ryrz got=%h want=%h", {acc_q[a0+k].y, acc_q[a0+k].z}, {y, z}); end
                total++; if (acc_q[a0+k].sh !== e[k]) begin bad++; $display("FAIL basic_shade pix=%0d got=%0d want=%0d", k, acc_q[a0+k].sh, e[k]); end
            end
            total++; if (ld_q[l0] != t0 + 41) begin bad++; $display("FAIL basic_line_done_time got=%0d want=%0d", ld_q[l0], t0 + 41); end
        end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_shade_map();
        bit          ch [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
        logic [15:0] cl [8] = '{16'd9999, 16'hFFFB, 16'h00FF, 16'h1A00, 16'h4000, 16'h7FFF, 16'h7FFF, 16'h8000};
        logic [5:0]  ce [8] = '{6'd0, 6'd1, 6'd1, 6'd26, 6'd63, 6'd63, 6'd0, 6'd1};
        logic [5:0]  dummy;
        int t0, a0, l0;
        bit ok;
        shade_ready = 1'b1;
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < int'(NPIX); k++) set_cfg(k, ch[ln*4+k], cl[ln*4+k], dummy);
            a0 = acc_q.size(); l0 = ld_q.size();
            pulse_line(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), t0);
            wait_ld(l0 + 1, 100, ok);
            total++; if (!ok || acc_q.size() - a0 != int'(NPIX)) begin bad++; $display("FAIL shade_map_timeout line=%0d got=%0d want=%0d", ln, acc_q.size() - a0, NPIX); end
            else begin
                for (int k = 0; k < int'(NPIX); k++) begin
                    total++; if (acc_q[a0+k].sh !== ce[ln*4+k]) begin bad++; $display("FAIL shade_map case=%0d got=%0d want=%0d", ln*4+k, acc_q[a0+k].sh, ce[ln*4+k]); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] e [NPIX];
        logic [5:0] sh;
        logic [PIXW-1:0] p;
        int t0, l0;
        bit ok;
        shade_ready = 1'b0;
        fill_rand(e);
        l0 = ld_q.size();
        pulse_line(16'h0040, 16'h0010, 16'h1111, 16'h2222, t0);
        wait_valid(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_valid_timeout got=0 want=1"); end
        sh = shade; p = pix_idx;
        total++; if ({p, sh} !== {PIXW'(0), e[0]}) begin bad++; $display("FAIL bp_first got=%h want=%h", {p, sh}, {PIXW'(0), e[0]}); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if ({shade_valid, hit_start, pix_idx, shade} !== {1'b1, 1'b0, p, sh}) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, {shade_valid, hit_start, pix_idx, shade}, {1'b1, 1'b0, p, sh}); end
        end
        shade_ready = 1'b1;
        step();
        total++; if ({hit_start, shade_valid, pix_idx} !== {1'b1, 1'b0, PIXW'(1)}) begin bad++; $display("FAIL bp_restart got=%h want=%h", {hit_start, shade_valid, pix_idx}, {1'b1, 1'b0, PIXW'(1)}); end
        wait_ld(l0 + 1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_line_done_timeout got=0 want=1"); end
    endtask

    task automatic test_abort();
        logic [5:0] e [NPIX];
        int t0, t1, a0, l0;
        bit ok;
        shade_ready = 1'b1;
        fill_rand(e);
        pulse_line(16'h0100, 16'h0100, 16'h0AAA, 16'h0BBB, t0);
        while (cyc < t0 + 25) step();
        total++; if ({pix_idx, shade_valid, busy} !== {PIXW'(2), 1'b0, 1'b1}) begin bad++; $display("FAIL abort_pre got=%h want=%h", {pix_idx, shade_valid, busy}, {PIXW'(2), 1'b0, 1'b1}); end
        fill_rand(e);
        a0 = acc_q.size(); l0 = ld_q.size();
        pulse_line(16'h1234, 16'h0008, 16'h5678, 16'h9ABC, t1);
        total++; if ({hit_start, shade_valid, busy, pix_idx} !== {1'b1, 1'b0, 1'b1, PIXW'(0)}) begin bad++; $display("FAIL abort_relaunch got=%h want=%h", {hit_start, shade_valid, busy, pix_idx}, {1'b1, 1'b0, 1'b1, PIXW'(0)}); end
        total++; if ({rx, ry, rz} !== {16'h1234, 16'h5678, 16'h9ABC}) begin bad++; $display("FAIL abort_ray got=%h want=%h", {rx, ry, rz}, {16'h1234, 16'h5678, 16'h9ABC}); end
        wait_ld(l0 + 1, 100, ok);
        total++; if (!ok || ld_q[l0] != t1 + 41) begin bad++; $display("FAIL abort_line_done got=%0d want=%0d", ok ? ld_q[l0] : -1, t1 + 41); end
        total++; if (acc_q.size() - a0 != int'(NPIX)) begin bad++; $display("FAIL abort_count got=%0d want=%0d", acc_q.size() - a0, NPIX); end
        else begin
            for (int k = 0; k < int'(NPIX); k++) begin
                total++; if ({acc_q[a0+k].x, acc_q[a0+k].sh} !== {16'(16'h1234 + 8*k), e[k]}) begin bad++; $display("FAIL abort_pixel k=%0d got=%h want=%h", k, {acc_q[a0+k].x, acc_q[a0+k].sh}, {16'(16'h1234 + 8*k), e[k]}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e [NPIX];
        int t0, t1, t2, l0;
        bit ok;
        shade_ready = 1'b1;
        fill_rand(e);
        pulse_line(16'h0000, 16'h0001, 16'h0002, 16'h0003, t0);
        while (cyc < t0 + 40) step();
        total++; if ({shade_valid, pix_idx} !== {1'b1, PIXW'(3)}) begin bad++; $display("FAIL b2b_final got=%h want=%h", {shade_valid, pix_idx}, {1'b1, PIXW'(3)}); end
        l0 = ld_q.size();
        fill_rand(e);
        pulse_line(16'h0500, 16'h0001, 16'h0006, 16'h0007, t1);
        total++; if ({line_done, hit_start, pix_idx, rx} !== {1'b0, 1'b1, PIXW'(0), 16'h0500}) begin bad++; $display("FAIL b2b_restart got=%h want=%h", {line_done, hit_start, pix_idx, rx}, {1'b0, 1'b1, PIXW'(0), 16'h0500}); end
        shade_ready = 1'b0;
        wait_valid(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_valid_timeout got=0 want=1"); end
        fill_rand(e);
        pulse_line(16'h0700, 16'h0001, 16'h0006, 16'h0007, t2);
        total++; if ({shade_valid, hit_start, rx} !== {1'b0, 1'b1, 16'h0700}) begin bad++; $display("FAIL b2b_emit_abort got=%h want=%h", {shade_valid, hit_start, rx}, {1'b0, 1'b1, 16'h0700}); end
        shade_ready = 1'b1;
        wait_ld(l0 + 1, 100, ok);
        step(); step();
        total++; if (!ok || ld_q.size() != l0 + 1 || ld_q[l0] != t2 + 41) begin bad++; $display("FAIL b2b_line_done got=%0d want=%0d", ld_q.size() - l0, 1); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e [NPIX];
        logic [65:0] o;
        int t0, a0, l0, viol;
        bit ok;
        shade_ready = 1'b0;
        fill_rand(e);
        pulse_line(16'h0F0F, 16'h0101, 16'h3333, 16'h4444, t0);
        wait_valid(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_valid_timeout got=0 want=1"); end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        o = {hit_start, rx, ry, rz, shade, pix_idx, shade_valid, line_done, busy};
        total++; if (o !== '0) begin bad++; $display("FAIL rst_async got=%h want=0", o); end
        step();
        rst_n = 1'b1;
        shade_ready = 1'b1;
        viol = 0;
        repeat (20) begin
            step();
            if (busy || hit_start || shade_valid || line_done) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL rst_stays_idle got=%0d want=0", viol); end
        fill_rand(e);
        a0 = acc_q.size(); l0 = ld_q.size();
        pulse_line(16'h0001, 16'h0001, 16'h0001, 16'h0001, t0);
        wait_ld(l0 + 1, 100, ok);
        total++; if (!ok || acc_q.size() - a0 != int'(NPIX) || acc_q[a0].sh !== e[0]) begin bad++; $display("FAIL rst_recover got=%0d want=%0d", acc_q.size() - a0, NPIX); end
    endtask

    task automatic test_rx_wrap();
        logic [5:0] e [NPIX];
        logic [15:0] want [NPIX] = '{16'h7F00, 16'h8100, 16'h8300, 16'h8500};
        int t0, a0, l0;
        bit ok;
        shade_ready = 1'b1;
        fill_rand(e);
        a0 = acc_q.size(); l0 = ld_q.size();
        pulse_line(16'h7F00, 16'h0200, 16'h0000, 16'h0000, t0);
        wait_ld(l0 + 1, 100, ok);
        total++; if (!ok || acc_q.size() - a0 != int'(NPIX)) begin bad++; $display("FAIL wrap_timeout got=%0d want=%0d", acc_q.size() - a0, NPIX); end
        else begin
            for (int k = 0; k < int'(NPIX); k++) begin
                total++; if (acc_q[a0+k].x !== want[k]) begin bad++; $display("FAIL wrap_rx pix=%0d got=%h want=%h", k, acc_q[a0+k].x, want[k]); end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] e [NPIX];
        logic [15:0] a, b, y, z;
        int t0, a0, l0, errs;
        bit ok;
        for (int ln = 0; ln < 8; ln++) begin
            fill_rand(e);
            a = 16'($urandom); b = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
            a0 = acc_q.size(); l0 = ld_q.size();
            shade_ready = 1'b1;
            pulse_line(a, b, y, z, t0);
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                shade_ready = ($urandom_range(0, 3) != 0);
                step();
                if (ld_q.size() > l0) begin ok = 1'b1; break; end
            end
            shade_ready = 1'b1;
            total++; if (!ok || acc_q.size() - a0 != int'(NPIX)) begin bad++; $display("FAIL rand_line=%0d count got=%0d want=%0d", ln, acc_q.size() - a0, NPIX); end
            else begin
                errs = 0;
                for (int k = 0; k < int'(NPIX); k++) begin
                    if (acc_q[a0+k].pix != k || acc_q[a0+k].sh !== e[k] ||
                        acc_q[a0+k].x !== 16'(int'(a) + k * int'(b)) ||
                        acc_q[a0+k].y !== y || acc_q[a0+k].z !== z) errs++;
                end
                total++; if (errs != 0) begin bad++; $display("FAIL rand_line=%0d pixels got=%0d_bad want=0", ln, errs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_shade_map();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_rx_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
